alu_src_b_stage: RTL and testbench

- Parametrised, registered successor to the combinational ALU operand-B selector in the multicycle datapath.
- Accepts operand requests (select code, immediate, register B value) through a valid/ready handshake and computes the selected/extended/shifted operand.
- Buffers results in a 2-entry queue so the ALU side can stall without losing a request.
- Sits between the register-B / instruction-register outputs and the ALU B input.

---
 rtl/alu_src_b_stage.sv | 139 +++++++++++++
 tb/tb_alu_src_b_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_src_b_stage.sv
// -----------------------------------------------------------------------------
// alu_src_b_stage
//
// Registered ALU operand-B source stage for the multicycle datapath. A request
// (select code, immediate, register B value) is accepted through a valid/ready
// handshake. The stage computes the selected, extended or shifted operand and
// stores it in a 2-entry FIFO. The ALU side can therefore stall without losing
// a request.
//
// Ports:
//   clk        in   1          rising-edge clock
//   reset      in   1          synchronous, active-high reset
//   in_valid   in   1          request present on sel/imm/regb
//   in_ready   out  1          stage can accept a request this cycle
//   sel        in   3          source select code
//   imm        in   IMM_WIDTH  immediate field
//   regb       in   WIDTH      register B value
//   out_valid  out  1          out_data/out_err hold a valid result
//   out_ready  in   1          consumer accepts the result this cycle
//   out_data   out  WIDTH      selected operand (head of queue)
//   out_err    out  1          head came from a reserved select code
//   count      out  2          queue occupancy (0..2)
// -----------------------------------------------------------------------------
module alu_src_b_stage #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int CONST_VAL = 4,
  parameter int SHIFT     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           sel,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic [WIDTH-1:0]     regb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic [1:0]           count
);

  typedef enum logic [2:0] {
    SRC_SEXT   = 3'b000,
    SRC_CONST  = 3'b001,
    SRC_REGB   = 3'b010,
    SRC_SHIFT  = 3'b011,
    SRC_ZEXT   = 3'b100,
    SRC_UPPER  = 3'b101
  } src_sel_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } entry_t;

  // Queue storage: entry0 is always the head, and entry1 is the one behind it.
  entry_t     entry0_q, entry0_d;
  entry_t     entry1_q, entry1_d;
  logic [1:0] count_q,  count_d;

  entry_t           new_entry;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] imm_zext;
  logic             push;
  logic             pop;

  assign imm_sext = {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign imm_zext = {{(WIDTH-IMM_WIDTH){1'b0}}, imm};

  // Operand decode. Shifts are done at WIDTH bits, so bits pushed past the
  // MSB are dropped.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    new_entry = '0;
    case (src_sel_e'(sel))
      SRC_SEXT:  new_entry.data = imm_sext;
      SRC_CONST: new_entry.data = WIDTH'(CONST_VAL);
      SRC_REGB:  new_entry.data = regb;
      SRC_SHIFT: new_entry.data = imm_sext << SHIFT;
      SRC_ZEXT:  new_entry.data = imm_zext;
      SRC_UPPER: new_entry.data = imm_zext << IMM_WIDTH;
      default:   new_entry.err  = 1'b1;  // reserved codes: data 0, err 1
    endcase
  end

  // in_ready depends only on registered occupancy. This keeps any
  // combinational path from out_ready out of the upstream handshake.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) entry0_d = new_entry;
        else                 entry1_d = new_entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Advance the queue. The vacated slot returns to zero so that no
        // stale value sits in unused storage.
        entry0_d = entry1_q;
        entry1_d = '0;
        count_d  = count_q - 2'd1;
      end
      2'b11: begin
        // A push can only happen together with a pop when count is 1. The
        // new entry replaces the departing head.
        entry0_d = new_entry;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: both queue slots are cleared on reset, because out_data exposes the head directly and must never show X.
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign out_data = entry0_q.data;
  assign out_err  = entry0_q.err;
  assign count    = count_q;

endmodule

// File: tb/tb_alu_src_b_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_src_b_stage
//
// Directed, self-checking bench for alu_src_b_stage with the default
// parameters (WIDTH=32, IMM_WIDTH=16, CONST_VAL=4, SHIFT=2). Inputs are
// driven 1 ns after each rising edge. Outputs are checked at that same
// point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_alu_src_b_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  sel;
  logic [15:0] imm;
  logic [31:0] regb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;

  alu_src_b_stage #(
    .WIDTH     (32),
    .IMM_WIDTH (16),
    .CONST_VAL (4),
    .SHIFT     (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .imm       (imm),
    .regb      (regb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Advance one rising edge, then settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full visible state of the stage in one call.
  task automatic check_state(input string tag, input logic [1:0] exp_count,
                             input logic [31:0] exp_data, input logic exp_err);
    check({tag, ".count"},     {30'd0, count},     {30'd0, exp_count});
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, (exp_count != 2'd0)});
    check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, (exp_count != 2'd2)});
    check({tag, ".out_data"},  out_data,           exp_data);
    check({tag, ".out_err"},   {31'd0, out_err},   {31'd0, exp_err});
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = 3'b000;
    imm       = 16'h0000;
    regb      = 32'h0;

    // Reset state. The first check is made while reset is still held.
    step();
    step();
    check_state("reset_held", 2'd0, 32'h0, 1'b0);
    reset = 1'b0;
    step();
    check_state("reset_idle", 2'd0, 32'h0, 1'b0);

    // Single push of sel=000: imm FFF0 is sign-extended.
    in_valid = 1'b1; sel = 3'b000; imm = 16'hFFF0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_state("sext", 2'd1, 32'hFFFFFFF0, 1'b0);
    step();
    check({"sext_drain", ".count"}, {30'd0, count}, 32'd0);
    check({"sext_drain", ".out_valid"}, {31'd0, out_valid}, 32'd0);

    // Back-to-back pushes with out_ready=1. One result appears per cycle.
    in_valid = 1'b1; sel = 3'b001; imm = 16'hFFFF;
    step();
    check_state("const", 2'd1, 32'h00000004, 1'b0);
    sel = 3'b011; imm = 16'h8001;
    step();
    check_state("shift", 2'd1, 32'hFFFE0004, 1'b0);
    sel = 3'b100; imm = 16'h8001;
    step();
    check_state("zext", 2'd1, 32'h00008001, 1'b0);
    sel = 3'b101; imm = 16'h1234;
    step();
    check_state("upper", 2'd1, 32'h12340000, 1'b0);
    in_valid = 1'b0;
    step();
    check({"b2b_drain", ".count"}, {30'd0, count}, 32'd0);

    // Stall: two register-B results fill the queue, and a third request waits.
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 3'b010; regb = 32'hDEADBEEF;
    step();
    check_state("stall_1", 2'd1, 32'hDEADBEEF, 1'b0);
    regb = 32'h00000001;
    step();
    check_state("stall_full", 2'd2, 32'hDEADBEEF, 1'b0);
    regb = 32'hCAFEF00D;          // third request: held off while count=2
    step();
    check_state("stall_hold", 2'd2, 32'hDEADBEEF, 1'b0);
    out_ready = 1'b1;             // DEADBEEF leaves; the third request is still blocked
    step();
    check_state("stall_pop", 2'd1, 32'h00000001, 1'b0);
    // in_ready=1 at count=1, so this edge pushes and pops together.
    step();
    check_state("push_pop", 2'd1, 32'hCAFEF00D, 1'b0);
    in_valid = 1'b0;
    step();
    check({"stall_drain", ".count"}, {30'd0, count}, 32'd0);

    // Reserved codes produce data 0 and err 1. A following sel=010 clears err.
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 3'b110; imm = 16'hFFFF; regb = 32'hFFFFFFFF;
    step();
    check_state("rsv_110", 2'd1, 32'h0, 1'b1);
    sel = 3'b111;
    step();
    check_state("rsv_full", 2'd2, 32'h0, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check_state("rsv_111", 2'd1, 32'h0, 1'b1);
    in_valid = 1'b1; sel = 3'b010; regb = 32'h12345678;
    step();
    check_state("rsv_after", 2'd1, 32'h12345678, 1'b0);
    in_valid = 1'b0;
    step();
    check({"rsv_drain", ".count"}, {30'd0, count}, 32'd0);

    // Reset with a full queue and a request pending.
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 3'b010; regb = 32'h0000AAAA;
    step();
    regb = 32'h0000BBBB;
    step();
    check_state("pre_reset", 2'd2, 32'h0000AAAA, 1'b0);
    reset = 1'b1; regb = 32'h0000CCCC; out_ready = 1'b1;
    step();
    check_state("mid_reset", 2'd0, 32'h0, 1'b0);
    reset = 1'b0; in_valid = 1'b0;
    step();
    check_state("post_reset", 2'd0, 32'h0, 1'b0);

    // Cleared storage: a single push must surface alone, with no stale entry behind it.
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 3'b001;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    check_state("fresh_push", 2'd1, 32'h00000004, 1'b0);
    step();
    check_state("fresh_drain", 2'd0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
